trace_match_trigger: RTL and testbench

- Parametrised successor to the single-channel trace pattern/mask matcher: N masked rules over a sliding window of trace bytes.
- Adds an arm/one-shot trigger FSM, pulse/toggle trigger output, and a first-word-fall-through event FIFO of {rule id, timestamp} records.
- Sits between the trace byte decoder and the register/USB readout block.
- Event record layout is the one the bench consumes: [63:56] rule, [55:0] cycle.

---
 rtl/trace_match_trigger.sv | 262 ++++++++++++++++++++++++++
 tb/tb_trace_match_trigger.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_match_trigger.sv
// Event FIFO: first-word-fall-through store of {rule, timestamp} records.
// Latency: a record pushed in cycle t is visible at data_o in cycle t+1.
// Backpressure: none upstream; a push into a full FIFO without a pop is refused.
module trace_match_trigger_fifo #(
    parameter int pDW    = 64,
    parameter int pDEPTH = 16
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           push_i,
    input  logic [pDW-1:0] data_i,
    input  logic           pop_i,
    output logic [pDW-1:0] data_o,
    output logic           empty_o,
    output logic           full_o
);
    localparam int AW = $clog2(pDEPTH);

    logic [pDW-1:0] mem_q [pDEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           wr_ok;
    logic           rd_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(pDEPTH));
    // A pop frees a slot in the same cycle, so push+pop at full is accepted.
    assign wr_ok   = push_i && (!full_o || pop_i);
    assign rd_ok   = pop_i && !empty_o;
    // Unread storage is masked so the head reads as zero while empty.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents need no reset because the output is gated by empty.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

// Trace matcher: N masked rules over a byte window, arm/one-shot trigger, event log.
// Latency: byte accepted in cycle t gives O_match / O_trigger / FIFO push in cycle t+1.
// Backpressure: none; bytes are always accepted, events are dropped (sticky flag) when the FIFO is full.
module trace_match_trigger #(
    parameter int pNUM_RULES    = 8,
    parameter int pWINDOW_BYTES = 8,
    parameter int pTS_WIDTH     = 56,
    parameter int pFIFO_DEPTH   = 16
) (
    input  logic                       trace_clk,
    input  logic                       reset,
    input  logic [7:0]                 I_data,
    input  logic                       I_data_valid,
    input  logic [pNUM_RULES*64-1:0]   I_pattern,
    input  logic [pNUM_RULES*64-1:0]   I_mask,
    input  logic [pNUM_RULES-1:0]      I_pattern_enable,
    input  logic [pNUM_RULES-1:0]      I_trig_enable,
    input  logic                       I_trig_toggle,
    input  logic                       I_oneshot,
    input  logic                       I_capture_enable,
    input  logic                       I_arm,
    input  logic                       I_fifo_rd,
    output logic [pNUM_RULES-1:0]      O_match,
    output logic                       O_trigger,
    output logic                       O_armed,
    output logic [63:0]                O_fifo_data,
    output logic                       O_fifo_empty,
    output logic                       O_fifo_overflow
);
    localparam int WB = pWINDOW_BYTES * 8;
    localparam int FW = $clog2(pWINDOW_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WB-1:0]          win_q, win_d, win_shift;
    logic [FW-1:0]          fill_q, fill_d, fill_inc;
    logic [pTS_WIDTH-1:0]   ts_q;
    logic [pNUM_RULES-1:0]  match_q, match_d;
    logic                   trig_q, trig_d;
    logic                   tog_q;
    logic                   ovf_q, ovf_d;
    logic [FW-1:0]          need [pNUM_RULES];
    logic [pNUM_RULES-1:0]  hit;
    logic [7:0]             low_id;
    logic                   fire;
    logic                   push;
    logic                   fifo_full;

    // New byte enters at the low end; older bytes move toward the top.
    generate
        if (pWINDOW_BYTES > 1) begin : g_shift
            assign win_shift = {win_q[WB-9:0], I_data};
        end else begin : g_single
            assign win_shift = I_data;
        end
    endgenerate

    assign fill_inc = (fill_q == FW'(pWINDOW_BYTES)) ? fill_q : fill_q + FW'(1);

    // Window and fill advance only on accepted bytes.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (I_data_valid) begin
            win_d  = win_shift;
            fill_d = fill_inc;
        end
    end

    // Per rule: bytes that must be present = highest masked byte index + 1 (0 = empty mask).
    always_comb begin
        for (int r = 0; r < pNUM_RULES; r++) begin
            need[r] = '0;
            for (int b = 0; b < pWINDOW_BYTES; b++) begin
                if (|I_mask[r*64 + b*8 +: 8]) begin
                    need[r] = FW'(b + 1);
                end
            end
        end
    end

    // Rule hits against the post-shift window, only on accepted bytes.
    always_comb begin
        hit = '0;
        for (int r = 0; r < pNUM_RULES; r++) begin
            hit[r] = I_data_valid
                  && I_pattern_enable[r]
                  && (need[r] != '0)
                  && (fill_inc >= need[r])
                  && (((win_shift ^ I_pattern[r*64 +: WB]) & I_mask[r*64 +: WB]) == '0);
        end
    end

    // Lowest-index hitting rule names the logged event.
    always_comb begin
        low_id = '0;
        for (int r = pNUM_RULES - 1; r >= 0; r--) begin
            if (hit[r]) begin
                low_id = 8'(r);
            end
        end
    end

    assign match_d = hit;
    assign push    = I_capture_enable && (|hit);

    // Arm FSM: arm wins over a coincident hit, so that hit never fires.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        if (I_arm) begin
            state_d = ST_ARMED;
        end else if ((state_q == ST_ARMED) && (|(hit & I_trig_enable))) begin
            fire = 1'b1;
            if (I_oneshot) begin
                state_d = ST_DONE;
            end
        end
    end

    // Trigger level: a mode change clears it, else pulse on fire or toggle on fire.
    always_comb begin
        trig_d = trig_q;
        if (I_trig_toggle != tog_q) begin
            trig_d = 1'b0;
        end else if (I_trig_toggle) begin
            trig_d = trig_q ^ fire;
        end else begin
            trig_d = fire;
        end
    end

    // Sticky overflow: arm clears it, a refused push sets it (set wins if both).
    always_comb begin
        ovf_d = ovf_q;
        if (I_arm) begin
            ovf_d = 1'b0;
        end
        if (push && fifo_full && !I_fifo_rd) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; everything returns to its idle value on reset.
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            fill_q  <= '0;
            ts_q    <= '0;
            match_q <= '0;
            trig_q  <= 1'b0;
            tog_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            ts_q    <= ts_q + pTS_WIDTH'(1);
            match_q <= match_d;
            trig_q  <= trig_d;
            tog_q   <= I_trig_toggle;
            ovf_q   <= ovf_d;
        end
    end

    trace_match_trigger_fifo #(
        .pDW    (64),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk_i   (trace_clk),
        .reset_i (reset),
        .push_i  (push),
        .data_i  ({low_id, 56'(ts_q)}),
        .pop_i   (I_fifo_rd),
        .data_o  (O_fifo_data),
        .empty_o (O_fifo_empty),
        .full_o  (fifo_full)
    );

    assign O_match         = match_q;
    assign O_trigger       = trig_q;
    assign O_armed         = (state_q == ST_ARMED);
    assign O_fifo_overflow = ovf_q;
endmodule

// File: tb/tb_trace_match_trigger.sv
// Bench for trace_match_trigger: directed scenarios plus randomized traffic.
// Expected values come from a byte-history / queue model of the matcher rules.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_trace_match_trigger;
    localparam int NR = 8;

    logic              trace_clk;
    logic              reset;
    logic [7:0]        I_data;
    logic              I_data_valid;
    logic [NR*64-1:0]  I_pattern;
    logic [NR*64-1:0]  I_mask;
    logic [NR-1:0]     I_pattern_enable;
    logic [NR-1:0]     I_trig_enable;
    logic              I_trig_toggle;
    logic              I_oneshot;
    logic              I_capture_enable;
    logic              I_arm;
    logic              I_fifo_rd;
    logic [NR-1:0]     O_match;
    logic              O_trigger;
    logic              O_armed;
    logic [63:0]       O_fifo_data;
    logic              O_fifo_empty;
    logic              O_fifo_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]       m_hist[$];   // newest byte at index 0
    logic [63:0]      m_fifo[$];
    bit               m_armed, m_trig, m_prev_tog, m_ovf;
    longint unsigned  m_ts;
    logic [NR-1:0]    exp_match;

    trace_match_trigger dut (
        .trace_clk        (trace_clk),
        .reset            (reset),
        .I_data           (I_data),
        .I_data_valid     (I_data_valid),
        .I_pattern        (I_pattern),
        .I_mask           (I_mask),
        .I_pattern_enable (I_pattern_enable),
        .I_trig_enable    (I_trig_enable),
        .I_trig_toggle    (I_trig_toggle),
        .I_oneshot        (I_oneshot),
        .I_capture_enable (I_capture_enable),
        .I_arm            (I_arm),
        .I_fifo_rd        (I_fifo_rd),
        .O_match          (O_match),
        .O_trigger        (O_trigger),
        .O_armed          (O_armed),
        .O_fifo_data      (O_fifo_data),
        .O_fifo_empty     (O_fifo_empty),
        .O_fifo_overflow  (O_fifo_overflow)
    );

    initial begin
        trace_clk = 1'b0;
        forever #5 trace_clk = ~trace_clk;
    end

    function automatic bit rule_hit(int r);
        int need = 0;
        logic [7:0] mb, pb;
        for (int b = 0; b < 8; b++) begin
            if (I_mask[r*64 + b*8 +: 8] != 8'h00) need = b + 1;
        end
        if (!I_pattern_enable[r] || need == 0 || m_hist.size() < need) return 1'b0;
        for (int b = 0; b < need; b++) begin
            mb = I_mask[r*64 + b*8 +: 8];
            pb = I_pattern[r*64 + b*8 +: 8];
            if (((m_hist[b] ^ pb) & mb) != 8'h00) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] exp_head();
        if (m_fifo.size() != 0) return m_fifo[0];
        return 64'h0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        I_data_valid = 1'b0; I_data = 8'h00; I_arm = 1'b0; I_fifo_rd = 1'b0;
        @(posedge trace_clk); #1;
        reset = 1'b0;
        m_hist.delete(); m_fifo.delete();
        m_armed = 0; m_trig = 0; m_prev_tog = 0; m_ovf = 0; m_ts = 0;
        exp_match = '0;
    endtask

    // Drive one cycle and advance the model to what the outputs must show after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit arm, input bit rd);
        logic [NR-1:0] h;
        bit fire, was_full;
        int lo;
        I_data_valid = v; I_data = d; I_arm = arm; I_fifo_rd = rd;
        h = '0;
        if (v) begin
            m_hist.push_front(d);
            if (m_hist.size() > 8) void'(m_hist.pop_back());
            for (int r = 0; r < NR; r++) h[r] = rule_hit(r);
        end
        was_full = (m_fifo.size() == 16);
        if (arm) m_ovf = 0;
        if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (I_capture_enable && h != '0) begin
            lo = -1;
            for (int r = 0; r < NR; r++) if (h[r] && lo < 0) lo = r;
            if (!was_full || rd) m_fifo.push_back({8'(lo), 56'(m_ts)});
            else m_ovf = 1;
        end
        fire = !arm && m_armed && ((h & I_trig_enable) != '0);
        if (I_trig_toggle != m_prev_tog) m_trig = 0;
        else if (I_trig_toggle) m_trig = m_trig ^ fire;
        else m_trig = fire;
        m_prev_tog = I_trig_toggle;
        if (arm) m_armed = 1;
        else if (fire && I_oneshot) m_armed = 0;
        m_ts++;
        exp_match = h;
        @(posedge trace_clk); #1;
        I_data_valid = 1'b0; I_arm = 1'b0; I_fifo_rd = 1'b0;
    endtask

    task automatic cfg_clear();
        I_pattern = '0; I_mask = '0; I_pattern_enable = '0; I_trig_enable = '0;
        I_trig_toggle = 0; I_oneshot = 0; I_capture_enable = 1;
    endtask

    task automatic test_reset();
        cfg_clear();
        do_reset();
        n_checks++; if (O_match !== 8'h00) $display("FAIL reset_match got %h want 00", O_match); else n_pass++;
        n_checks++; if (O_trigger !== 1'b0) $display("FAIL reset_trigger got %b want 0", O_trigger); else n_pass++;
        n_checks++; if (O_armed !== 1'b0) $display("FAIL reset_armed got %b want 0", O_armed); else n_pass++;
        n_checks++; if (O_fifo_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", O_fifo_empty); else n_pass++;
        n_checks++; if (O_fifo_overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", O_fifo_overflow); else n_pass++;
        n_checks++; if (O_fifo_data !== 64'h0) $display("FAIL reset_data got %h want 0", O_fifo_data); else n_pass++;
    endtask

    task automatic test_basic_match();
        cfg_clear();
        do_reset();
        I_pattern[15:0] = 16'h5AA5; I_mask[15:0] = 16'hFFFF;   // byte1=5A (older), byte0=A5 (newest)
        I_pattern_enable = 8'h01; I_trig_enable = 8'h01;
        step(0, 8'h00, 1, 0);
        n_checks++; if (O_armed !== 1'b1) $display("FAIL basic_armed got %b want 1", O_armed); else n_pass++;
        step(1, 8'h5A, 0, 0);
        n_checks++; if (O_match !== 8'h00) $display("FAIL basic_first_byte got %h want 00", O_match); else n_pass++;
        step(1, 8'hA5, 0, 0);
        n_checks++; if (O_match !== 8'h01) $display("FAIL basic_match got %h want 01", O_match); else n_pass++;
        n_checks++; if (O_trigger !== 1'b1) $display("FAIL basic_trigger got %b want 1", O_trigger); else n_pass++;
        n_checks++; if (O_fifo_data !== 64'h0000_0000_0000_0002) $display("FAIL basic_entry got %h want 0000000000000002", O_fifo_data); else n_pass++;
        step(0, 8'h00, 0, 0);
        n_checks++; if (O_match !== 8'h00 || O_trigger !== 1'b0) $display("FAIL basic_pulse_end got match=%h trig=%b want 00/0", O_match, O_trigger); else n_pass++;
        step(0, 8'h00, 0, 1);
        n_checks++; if (O_fifo_empty !== 1'b1 || O_fifo_data !== 64'h0) $display("FAIL basic_pop got empty=%b data=%h want 1/0", O_fifo_empty, O_fifo_data); else n_pass++;
    endtask

    task automatic test_fill();
        cfg_clear();
        do_reset();
        I_mask[127:64] = '1;          // rule1 compares all 8 bytes against zero
        I_pattern_enable = 8'h02;
        for (int i = 0; i < 7; i++) begin
            step(1, 8'h00, 0, 0);
            n_checks++; if (O_match !== 8'h00) $display("FAIL fill_early byte %0d got %h want 00", i, O_match); else n_pass++;
        end
        step(1, 8'h00, 0, 0);
        n_checks++; if (O_match !== 8'h02) $display("FAIL fill_full got %h want 02", O_match); else n_pass++;
        n_checks++; if (O_fifo_data !== 64'h0100_0000_0000_0007) $display("FAIL fill_entry got %h want 0100000000000007", O_fifo_data); else n_pass++;
        step(1, 8'h00, 0, 0);
        n_checks++; if (O_match !== 8'h02) $display("FAIL fill_saturated got %h want 02", O_match); else n_pass++;
    endtask

    task automatic test_multi_rule();
        cfg_clear();
        do_reset();
        I_pattern[2*64 +: 8]  = 8'h77;   I_mask[2*64 +: 8]  = 8'hFF;
        I_pattern[5*64 +: 16] = 16'h7777; I_mask[5*64 +: 16] = 16'hFFFF;
        I_pattern_enable = 8'h2C;        // rule3 enabled with an all-zero mask
        step(1, 8'h77, 0, 0);
        n_checks++; if (O_match !== 8'h04) $display("FAIL multi_first got %h want 04", O_match); else n_pass++;
        step(1, 8'h77, 0, 0);
        n_checks++; if (O_match !== 8'h24) $display("FAIL multi_both got %h want 24", O_match); else n_pass++;
        n_checks++; if (O_fifo_data !== 64'h0200_0000_0000_0000) $display("FAIL multi_head0 got %h want 0200000000000000", O_fifo_data); else n_pass++;
        step(0, 8'h00, 0, 1);
        n_checks++; if (O_fifo_data !== 64'h0200_0000_0000_0001) $display("FAIL multi_head1 got %h want 0200000000000001", O_fifo_data); else n_pass++;
        step(0, 8'h00, 0, 1);
        n_checks++; if (O_fifo_empty !== 1'b1) $display("FAIL multi_single_entry got empty=%b want 1", O_fifo_empty); else n_pass++;
    endtask

    task automatic test_toggle_oneshot();
        int pops;
        cfg_clear();
        do_reset();
        I_pattern[7:0] = 8'h11; I_mask[7:0] = 8'hFF;
        I_pattern_enable = 8'h01; I_trig_enable = 8'h01; I_trig_toggle = 1;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'h11, 0, 0);
        n_checks++; if (O_trigger !== 1'b1) $display("FAIL toggle_1 got %b want 1", O_trigger); else n_pass++;
        step(1, 8'h00, 0, 0);
        n_checks++; if (O_trigger !== 1'b1) $display("FAIL toggle_hold got %b want 1", O_trigger); else n_pass++;
        step(1, 8'h11, 0, 0);
        n_checks++; if (O_trigger !== 1'b0) $display("FAIL toggle_2 got %b want 0", O_trigger); else n_pass++;
        step(1, 8'h11, 0, 0);
        n_checks++; if (O_trigger !== 1'b1) $display("FAIL toggle_3 got %b want 1", O_trigger); else n_pass++;
        I_trig_toggle = 0;
        step(0, 8'h00, 0, 0);
        n_checks++; if (O_trigger !== 1'b0) $display("FAIL mode_change got %b want 0", O_trigger); else n_pass++;
        I_trig_toggle = 1;
        step(0, 8'h00, 0, 0);
        I_oneshot = 1;
        step(1, 8'h11, 0, 0);
        n_checks++; if (O_trigger !== 1'b1 || O_armed !== 1'b0) $display("FAIL oneshot_fire got trig=%b armed=%b want 1/0", O_trigger, O_armed); else n_pass++;
        step(1, 8'h11, 0, 0);
        n_checks++; if (O_trigger !== 1'b1 || O_match !== 8'h01) $display("FAIL oneshot_done got trig=%b match=%h want 1/01", O_trigger, O_match); else n_pass++;
        pops = 0;
        for (int i = 0; i < 20 && O_fifo_empty === 1'b0; i++) begin
            step(0, 8'h00, 0, 1);
            pops++;
        end
        n_checks++; if (pops != 5) $display("FAIL toggle_logged got %0d entries want 5", pops); else n_pass++;
    endtask

    task automatic test_fifo_overflow();
        cfg_clear();
        do_reset();
        I_pattern[7:0] = 8'h11; I_mask[7:0] = 8'hFF; I_pattern_enable = 8'h01;
        for (int i = 0; i < 17; i++) step(1, 8'h11, 0, 0);
        n_checks++; if (O_fifo_overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", O_fifo_overflow); else n_pass++;
        n_checks++; if (O_fifo_data !== 64'h0) $display("FAIL ovf_head got %h want 0", O_fifo_data); else n_pass++;
        step(0, 8'h00, 1, 0);
        n_checks++; if (O_fifo_overflow !== 1'b0) $display("FAIL ovf_arm_clear got %b want 0", O_fifo_overflow); else n_pass++;
        step(1, 8'h11, 0, 1);
        n_checks++; if (O_fifo_overflow !== 1'b0) $display("FAIL ovf_push_pop_full got %b want 0", O_fifo_overflow); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (O_fifo_data !== exp_head()) $display("FAIL ovf_drain %0d got %h want %h", i, O_fifo_data, exp_head()); else n_pass++;
            step(0, 8'h00, 0, 1);
        end
        n_checks++; if (O_fifo_empty !== 1'b1) $display("FAIL ovf_drained got empty=%b want 1", O_fifo_empty); else n_pass++;
        step(0, 8'h00, 0, 1);
        n_checks++; if (O_fifo_empty !== 1'b1 || O_fifo_data !== 64'h0) $display("FAIL rd_when_empty got empty=%b data=%h want 1/0", O_fifo_empty, O_fifo_data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        cfg_clear();
        do_reset();
        I_pattern[15:0] = 16'h5AA5; I_mask[15:0] = 16'hFFFF;
        I_pattern_enable = 8'h01; I_trig_enable = 8'h01; I_trig_toggle = 1;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'h5A, 0, 0);
        step(1, 8'hA5, 0, 0);
        n_checks++; if (O_trigger !== 1'b1) $display("FAIL rstmid_pre got %b want 1", O_trigger); else n_pass++;
        step(1, 8'h5A, 0, 0);
        do_reset();
        n_checks++; if (O_trigger !== 1'b0 || O_armed !== 1'b0 || O_match !== 8'h00) $display("FAIL rstmid_outputs got trig=%b armed=%b match=%h want 0/0/00", O_trigger, O_armed, O_match); else n_pass++;
        n_checks++; if (O_fifo_empty !== 1'b1 || O_fifo_overflow !== 1'b0 || O_fifo_data !== 64'h0) $display("FAIL rstmid_fifo got empty=%b ovf=%b data=%h want 1/0/0", O_fifo_empty, O_fifo_overflow, O_fifo_data); else n_pass++;
        step(1, 8'hA5, 0, 0);
        n_checks++; if (O_match !== 8'h00) $display("FAIL rstmid_partial got %h want 00", O_match); else n_pass++;
        step(1, 8'h5A, 0, 0);
        step(1, 8'hA5, 0, 0);
        n_checks++; if (O_match !== 8'h01) $display("FAIL rstmid_resent got %h want 01", O_match); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] alpha [4];
        logic [7:0] d;
        int nb, sel;
        alpha[0] = 8'h5A; alpha[1] = 8'hA5; alpha[2] = 8'h11; alpha[3] = 8'h3C;
        cfg_clear();
        do_reset();
        for (int r = 0; r < NR; r++) begin
            nb = $urandom_range(0, 2);
            for (int b = 0; b <= nb; b++) begin
                I_pattern[r*64 + b*8 +: 8] = alpha[$urandom_range(0, 1)];
                sel = $urandom_range(0, 2);
                I_mask[r*64 + b*8 +: 8] = (sel == 0) ? 8'hFF : ((sel == 1) ? 8'hF0 : 8'h00);
            end
        end
        I_pattern_enable = 8'($urandom);
        I_trig_enable = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 49) == 0) I_trig_toggle = ~I_trig_toggle;
            if ($urandom_range(0, 19) == 0) I_oneshot = ~I_oneshot;
            I_capture_enable = ($urandom_range(0, 9) != 0);
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : alpha[$urandom_range(0, 1)];
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
            n_checks++; if (O_match !== exp_match) $display("FAIL rand_match c%0d got %h want %h", c, O_match, exp_match); else n_pass++;
            n_checks++; if (O_trigger !== m_trig) $display("FAIL rand_trigger c%0d got %b want %b", c, O_trigger, m_trig); else n_pass++;
            n_checks++; if (O_armed !== m_armed) $display("FAIL rand_armed c%0d got %b want %b", c, O_armed, m_armed); else n_pass++;
            n_checks++; if (O_fifo_empty !== (m_fifo.size() == 0)) $display("FAIL rand_empty c%0d got %b want %b", c, O_fifo_empty, m_fifo.size() == 0); else n_pass++;
            n_checks++; if (O_fifo_overflow !== m_ovf) $display("FAIL rand_overflow c%0d got %b want %b", c, O_fifo_overflow, m_ovf); else n_pass++;
            n_checks++; if (O_fifo_data !== exp_head()) $display("FAIL rand_data c%0d got %h want %h", c, O_fifo_data, exp_head()); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        I_data = 8'h00; I_data_valid = 1'b0; I_arm = 1'b0; I_fifo_rd = 1'b0;
        cfg_clear();
        test_reset();
        test_basic_match();
        test_fill();
        test_multi_rule();
        test_toggle_oneshot();
        test_fifo_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
